// File: rtl/nios_pio_pkg.sv
// Shared constants for the nios_pio_ext GPIO block: register word addresses,
// edge-capture selection codes and the Avalon data width.
package nios_pio_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/nios_pio_ext_if.sv
// Avalon-MM slave bus bundle for nios_pio_ext (address, strobes, data, irq).
interface nios_pio_ext_if
    import nios_pio_pkg::*;
;
    logic [2:0]        address;
    logic              chipselect;
    logic              read_n;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              irq;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/nios_pio_sync.sv
// Input synchroniser (SYNC_STAGES flops) followed by a one-cycle history
// register and per-bit edge detection selected by EDGE_TYPE.
module nios_pio_sync
    import nios_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned EDGE_TYPE   = EDGE_RISE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] edges
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];
    logic [WIDTH-1:0] prev;

    // Shift pins through the synchroniser chain; prev always follows sync_in.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
            prev <= '0;
        end else begin
            stage[0] <= in_port;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
            prev <= stage[SYNC_STAGES-1];
        end
    end

    assign sync_in = stage[SYNC_STAGES-1];

    // Select the edge polarity that feeds edge capture.
    always_comb begin
        edges = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edges = sync_in & ~prev;
            EDGE_FALL: edges = ~sync_in & prev;
            default:   edges = sync_in ^ prev;
        endcase
    end

endmodule

// File: rtl/nios_pio_ext.sv
// nios_pio_ext: parametrised Avalon-MM GPIO with per-bit direction, synchronised
// inputs, edge capture with interrupt mask and a one-cycle registered read path.
// Optional build macro NIOS_PIO_BITSET_EN enables OUTSET (4) / OUTCLEAR (5).
module nios_pio_ext
    import nios_pio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '1,
    parameter int unsigned      EDGE_TYPE   = EDGE_RISE,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    nios_pio_ext_if.slave    bus,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port
);

    logic [WIDTH-1:0]  data_out;
    logic [WIDTH-1:0]  dir;
    logic [WIDTH-1:0]  irq_mask;
    logic [WIDTH-1:0]  edge_cap;
    logic [WIDTH-1:0]  sync_in;
    logic [WIDTH-1:0]  edges;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  clear_mask;
    logic [WIDTH-1:0]  read_word;
    logic [DATA_W-1:0] readdata_q;
    logic              irq_q;
    logic              wr_en;
    logic              rd_en;
    logic              unused_wdata;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign rd_en        = bus.chipselect & ~bus.read_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    nios_pio_sync #(
        .WIDTH       (WIDTH),
        .EDGE_TYPE   (EDGE_TYPE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .sync_in (sync_in),
        .edges   (edges)
    );

    // Write-one-to-clear mask for the edge capture register.
    always_comb begin
        clear_mask = '0;
        if (wr_en && bus.address == ADDR_EDGE_CAP) begin
            clear_mask = wdata;
        end
    end

    // Read mux over current register contents (pre-write on a same-cycle write).
    always_comb begin
        read_word = '0;
        case (bus.address)
            ADDR_DATA:     read_word = (data_out & dir) | (sync_in & ~dir);
            ADDR_DIR:      read_word = dir;
            ADDR_IRQ_MASK: read_word = irq_mask;
            ADDR_EDGE_CAP: read_word = edge_cap;
            default:       read_word = '0;
        endcase
    end

    // Control registers written from the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= OUT_RESET;
            dir      <= DIR_RESET;
            irq_mask <= '0;
        end else if (wr_en) begin
            case (bus.address)
                ADDR_DATA:     data_out <= wdata;
                ADDR_DIR:      dir      <= wdata;
                ADDR_IRQ_MASK: irq_mask <= wdata;
`ifdef NIOS_PIO_BITSET_EN
                ADDR_OUTSET:   data_out <= data_out | wdata;
                ADDR_OUTCLEAR: data_out <= data_out & ~wdata;
`else
                ADDR_OUTSET, ADDR_OUTCLEAR: ;
`endif
                default: ;
            endcase
        end
    end

    // Edge capture (set wins over a same-cycle clear) and registered interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_cap <= '0;
            irq_q    <= 1'b0;
        end else begin
            edge_cap <= (edge_cap & ~clear_mask) | (edges & ~dir);
            irq_q    <= |(edge_cap & irq_mask);
        end
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q <= '0;
        end else if (rd_en) begin
            readdata_q <= DATA_W'(read_word);
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = irq_q;
    assign out_port     = data_out;
    assign oe_port      = dir;

endmodule

// File: tb/tb_nios_pio_ext.sv
// Self-checking bench for nios_pio_ext (WIDTH=8, OUT_RESET=0xA5, rising edges).
module tb_nios_pio_ext;

    localparam int unsigned W    = 8;
    localparam int unsigned SYNC = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_port;
    logic [W-1:0] out_port;
    logic [W-1:0] oe_port;

    int n_tests = 0;
    int n_fail  = 0;

    nios_pio_ext_if bus ();

    nios_pio_ext #(
        .WIDTH       (W),
        .OUT_RESET   (8'hA5),
        .DIR_RESET   (8'hFF),
        .EDGE_TYPE   (0),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk      (clk),
        .reset    (rst),
        .bus      (bus),
        .in_port  (in_port),
        .out_port (out_port),
        .oe_port  (oe_port)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [W-1:0]  m_out, m_dir, m_mask, m_cap;
    logic          m_irq;
    logic [31:0]   m_rd;
    logic [W-1:0]  hist [0:SYNC];   // hist[k]: pin value sampled k+1 edges ago

    // Advance one clock: model computes next state from the inputs presented
    // for this edge, then DUT and model are both observed 1 time unit later.
    task automatic tick();
        logic [W-1:0] sync_v, prev_v, ev, clr, wd, n_out, n_dir, n_mask;
        logic [31:0]  rv;
        sync_v = hist[SYNC-1];
        prev_v = hist[SYNC];
        ev     = sync_v & ~prev_v & ~m_dir;
        wd     = bus.writedata[W-1:0];
        clr    = '0;
        n_out  = m_out;
        n_dir  = m_dir;
        n_mask = m_mask;
        case (bus.address)
            3'd0:    rv = 32'((m_out & m_dir) | (sync_v & ~m_dir));
            3'd1:    rv = 32'(m_dir);
            3'd2:    rv = 32'(m_mask);
            3'd3:    rv = 32'(m_cap);
            default: rv = 32'd0;
        endcase
        if (bus.chipselect && !bus.write_n) begin
            case (bus.address)
                3'd0: n_out  = wd;
                3'd1: n_dir  = wd;
                3'd2: n_mask = wd;
                3'd3: clr    = wd;
`ifdef NIOS_PIO_BITSET_EN
                3'd4: n_out  = m_out | wd;
                3'd5: n_out  = m_out & ~wd;
`endif
                default: ;
            endcase
        end
        @(posedge clk);
        if (rst) begin
            m_out = 8'hA5; m_dir = 8'hFF; m_mask = '0; m_cap = '0;
            m_irq = 1'b0;  m_rd = '0;
            for (int k = 0; k <= SYNC; k++) hist[k] = '0;
        end else begin
            if (bus.chipselect && !bus.read_n) m_rd = rv;
            m_irq = |(m_cap & m_mask);
            m_cap = (m_cap & ~clr) | ev;
            m_out = n_out; m_dir = n_dir; m_mask = n_mask;
            for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = in_port;
        end
        #1;
    endtask

    task automatic idle();
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        bus.write_n    = 1'b1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.read_n     = 1'b1;
        bus.address    = a;
        bus.writedata  = d;
        tick();
        idle();
    endtask

    task automatic do_read(input logic [2:0] a, output logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = a;
        tick();
        d = bus.readdata;
        idle();
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_tests++; if (out_port !== 8'hA5) begin n_fail++; $display("FAIL reset_out: got %h expected a5", out_port); end
        n_tests++; if (oe_port !== 8'hFF) begin n_fail++; $display("FAIL reset_oe: got %h expected ff", oe_port); end
        n_tests++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
        n_tests++; if (bus.readdata !== 32'd0) begin n_fail++; $display("FAIL reset_rd: got %h expected 0", bus.readdata); end
        do_read(3'd0, r);
        n_tests++; if (r !== 32'h0000_00A5) begin n_fail++; $display("FAIL reset_read_data: got %h expected 000000a5", r); end
    endtask

    task automatic test_data_mix();
        logic [31:0] r;
        do_write(3'd1, 32'h0F);
        do_write(3'd0, 32'hFF);
        in_port = 8'h30;
        repeat (3) tick();
        do_read(3'd0, r);
        n_tests++; if (r !== 32'h3F) begin n_fail++; $display("FAIL data_mix: got %h expected 3f", r); end
    endtask

    task automatic test_edge_irq();
        logic [31:0] r;
        do_write(3'd1, 32'h00);
        in_port = 8'h00;
        repeat (4) tick();
        do_write(3'd3, 32'hFF);
        do_write(3'd2, 32'h10);
        tick();
        n_tests++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b expected 0", bus.irq); end
        in_port = 8'h10;
        repeat (3) tick();
        n_tests++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b expected 0", bus.irq); end
        tick();
        n_tests++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b expected 1", bus.irq); end
        do_read(3'd3, r);
        n_tests++; if (r !== 32'h10) begin n_fail++; $display("FAIL edge_cap: got %h expected 10", r); end
        do_write(3'd3, 32'h10);
        n_tests++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold: got %b expected 1", bus.irq); end
        tick();
        n_tests++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b expected 0", bus.irq); end
    endtask

    task automatic test_clear_race();
        logic [31:0] r;
        in_port = 8'h14;
        repeat (4) tick();
        in_port = 8'h10;
        repeat (3) tick();
        in_port = 8'h14;
        tick();
        tick();
        do_write(3'd3, 32'h04);
        do_read(3'd3, r);
        n_tests++; if (r !== 32'h04) begin n_fail++; $display("FAIL clear_race: got %h expected 04", r); end
        do_write(3'd3, 32'h04);
        do_read(3'd3, r);
        n_tests++; if (r !== 32'h00) begin n_fail++; $display("FAIL clear_plain: got %h expected 00", r); end
    endtask

    task automatic test_bitset();
        logic [31:0] r;
        logic [W-1:0] exp_out;
`ifdef NIOS_PIO_BITSET_EN
        exp_out = 8'hFC;
`else
        exp_out = 8'h0F;
`endif
        do_write(3'd1, 32'hFF);
        do_write(3'd0, 32'h0F);
        do_write(3'd4, 32'hF0);
        do_write(3'd5, 32'h03);
        n_tests++; if (out_port !== exp_out) begin n_fail++; $display("FAIL bitset_out: got %h expected %h", out_port, exp_out); end
        do_read(3'd4, r);
        n_tests++; if (r !== 32'd0) begin n_fail++; $display("FAIL bitset_read: got %h expected 0", r); end
    endtask

    task automatic test_width();
        logic [31:0] r;
        do_write(3'd0, 32'hFFFF_FFFF);
        do_read(3'd0, r);
        n_tests++; if (r !== 32'h0000_00FF) begin n_fail++; $display("FAIL width_read: got %h expected 000000ff", r); end
        do_write(3'd7, 32'h5A5A_5A5A);
        do_read(3'd7, r);
        n_tests++; if (r !== 32'd0) begin n_fail++; $display("FAIL reserved_read: got %h expected 0", r); end
        n_tests++; if (out_port !== 8'hFF) begin n_fail++; $display("FAIL reserved_write: got %h expected ff", out_port); end
    endtask

    task automatic test_reset_mid_read();
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        bus.address    = 3'd1;
        rst            = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        n_tests++; if (bus.readdata !== 32'd0) begin n_fail++; $display("FAIL reset_mid_read: got %h expected 0", bus.readdata); end
        n_tests++; if (out_port !== 8'hA5) begin n_fail++; $display("FAIL reset_mid_out: got %h expected a5", out_port); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.chipselect = ($urandom_range(0, 3) != 0);
            bus.read_n     = $urandom_range(0, 1) == 1;
            bus.write_n    = $urandom_range(0, 2) != 0;
            bus.address    = 3'($urandom_range(0, 7));
            bus.writedata  = $urandom;
            if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
            tick();
            n_tests++; if (bus.readdata !== m_rd) begin n_fail++; $display("FAIL rand_rd[%0d]: got %h expected %h", i, bus.readdata, m_rd); end
            n_tests++; if (bus.irq !== m_irq) begin n_fail++; $display("FAIL rand_irq[%0d]: got %b expected %b", i, bus.irq, m_irq); end
            n_tests++; if (out_port !== m_out) begin n_fail++; $display("FAIL rand_out[%0d]: got %h expected %h", i, out_port, m_out); end
            n_tests++; if (oe_port !== m_dir) begin n_fail++; $display("FAIL rand_oe[%0d]: got %h expected %h", i, oe_port, m_dir); end
        end
        idle();
    endtask

    initial begin
        rst           = 1'b1;
        in_port       = '0;
        bus.address   = '0;
        bus.writedata = '0;
        idle();
        test_reset();
        test_data_mix();
        test_edge_irq();
        test_clear_race();
        test_bitset();
        test_width();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
